// File: rtl/grf_multiport_sb.sv
// General register file: NREAD combinational read ports with same-cycle write
// bypass, NWRITE write ports (higher index = younger), and a per-register
// pending-write scoreboard that drives the hazard unit's RBusy/IssueReady.
module grf_multiport_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2,
    parameter int unsigned PEND_W = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NREAD*ADDR_W-1:0]    RAddr,
    output logic [NREAD*DATA_W-1:0]    RData,
    output logic [NREAD-1:0]           RBusy,
    input  logic [NWRITE-1:0]          WEn,
    input  logic [NWRITE*ADDR_W-1:0]   WAddr,
    input  logic [NWRITE*DATA_W-1:0]   WData,
    input  logic [NWRITE-1:0]          WRetire,
    input  logic                       IssueEn,
    input  logic [ADDR_W-1:0]          IssueAddr,
    output logic                       IssueReady,
    output logic                       ErrUnderflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned DEC_W = $clog2(NWRITE + 1);
    localparam int unsigned SUM_W = PEND_W + DEC_W + 1;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs    [DEPTH];
    logic [PEND_W-1:0] cnt     [DEPTH];
    logic [PEND_W-1:0] cnt_nxt [DEPTH];
    logic [DEC_W-1:0]  dec     [DEPTH];
    logic              issue_take;
    logic              any_underflow;

    // Number of retiring write ports targeting each register this cycle
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            dec[r] = '0;
            for (int w = 0; w < NWRITE; w++) begin
                if (r != 0 && WEn[w] && WRetire[w] &&
                    WAddr[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    dec[r] = dec[r] + DEC_W'(1);
                end
            end
        end
    end

    // Issue is refused only when the destination counter is saturated and nothing retires it
    always_comb begin
        IssueReady = 1'b1;
        if (IssueAddr != '0) begin
            IssueReady = (cnt[IssueAddr] != CNT_MAX) || (dec[IssueAddr] != '0);
        end
        issue_take = IssueEn && IssueReady && (IssueAddr != '0);
    end

    // Next pending count per register; over-retire clamps to zero and flags underflow
    always_comb begin
        any_underflow = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt[r] = cnt[r];
            if (SUM_W'(dec[r]) > SUM_W'(cnt[r])) begin
                cnt_nxt[r]    = '0;
                any_underflow = 1'b1;
            end else begin
                cnt_nxt[r] = PEND_W'(SUM_W'(cnt[r])
                                     + SUM_W'(issue_take && (IssueAddr == ADDR_W'(r)))
                                     - SUM_W'(dec[r]));
            end
        end
    end

    // Busy unless the pending count is zero or a retire this cycle drains it
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            RBusy[i] = (cnt[RAddr[i*ADDR_W +: ADDR_W]] != '0) &&
                       !((dec[RAddr[i*ADDR_W +: ADDR_W]] != '0) &&
                         (cnt_nxt[RAddr[i*ADDR_W +: ADDR_W]] == '0));
        end
    end

    // Read mux with youngest-write-wins bypass; register 0 is never written so it reads 0
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            RData[i*DATA_W +: DATA_W] = regs[RAddr[i*ADDR_W +: ADDR_W]];
            for (int w = 0; w < NWRITE; w++) begin
                if (WEn[w] && RAddr[i*ADDR_W +: ADDR_W] != '0 &&
                    WAddr[w*ADDR_W +: ADDR_W] == RAddr[i*ADDR_W +: ADDR_W]) begin
                    RData[i*DATA_W +: DATA_W] = WData[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Storage, scoreboard and sticky error update; later ports overwrite earlier ones
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            ErrUnderflow <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            for (int w = 0; w < NWRITE; w++) begin
                if (WEn[w] && WAddr[w*ADDR_W +: ADDR_W] != '0) begin
                    regs[WAddr[w*ADDR_W +: ADDR_W]] <= WData[w*DATA_W +: DATA_W];
                end
            end
            if (any_underflow) begin
                ErrUnderflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grf_multiport_sb.sv
// Bench for grf_multiport_sb: directed vector table, reset checks, then random
// traffic compared against a behavioural register-file/scoreboard model.
module tb_grf_multiport_sb;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NR   = 2;
    localparam int unsigned NW   = 2;
    localparam int          CMAX = 3;

    logic               Clk;
    logic               Reset;
    logic [NR*AW-1:0]   RAddr;
    logic [NR*DW-1:0]   RData;
    logic [NR-1:0]      RBusy;
    logic [NW-1:0]      WEn;
    logic [NW*AW-1:0]   WAddr;
    logic [NW*DW-1:0]   WData;
    logic [NW-1:0]      WRetire;
    logic               IssueEn;
    logic [AW-1:0]      IssueAddr;
    logic               IssueReady;
    logic               ErrUnderflow;

    int n_cmp = 0;
    int n_err = 0;

    grf_multiport_sb dut (
        .Clk(Clk), .Reset(Reset), .RAddr(RAddr), .RData(RData), .RBusy(RBusy),
        .WEn(WEn), .WAddr(WAddr), .WData(WData), .WRetire(WRetire),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr), .IssueReady(IssueReady),
        .ErrUnderflow(ErrUnderflow)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mreg [32];
    int            mcnt [32];
    bit            merr;

    function automatic int m_dec(int a);
        int d = 0;
        if (a == 0) return 0;
        for (int w = 0; w < NW; w++)
            if (WEn[w] && WRetire[w] && int'(WAddr[w*AW +: AW]) == a) d++;
        return d;
    endfunction

    function automatic bit m_ready();
        int a = int'(IssueAddr);
        return (a == 0) || (mcnt[a] != CMAX) || (m_dec(a) > 0);
    endfunction

    function automatic int m_next(int a);
        int inc = (IssueEn && m_ready() && int'(IssueAddr) == a && a != 0) ? 1 : 0;
        int d   = m_dec(a);
        if (d > mcnt[a]) return 0;
        return mcnt[a] + inc - d;
    endfunction

    function automatic logic [DW-1:0] m_rdata(int p);
        int a = int'(RAddr[p*AW +: AW]);
        logic [DW-1:0] v = (a == 0) ? '0 : mreg[a];
        for (int w = 0; w < NW; w++)
            if (a != 0 && WEn[w] && int'(WAddr[w*AW +: AW]) == a) v = WData[w*DW +: DW];
        return v;
    endfunction

    function automatic bit m_busy(int p);
        int a = int'(RAddr[p*AW +: AW]);
        return (mcnt[a] != 0) && !(m_dec(a) > 0 && m_next(a) == 0);
    endfunction

    function automatic void m_step();
        int nx [32];
        bit uf = 0;
        if (Reset) begin
            for (int a = 0; a < 32; a++) begin
                mreg[a] = '0;
                mcnt[a] = 0;
            end
            merr = 0;
            return;
        end
        for (int a = 0; a < 32; a++) begin
            if (m_dec(a) > mcnt[a]) uf = 1;
            nx[a] = m_next(a);
        end
        for (int a = 0; a < 32; a++) mcnt[a] = nx[a];
        if (uf) merr = 1;
        for (int w = 0; w < NW; w++)
            if (WEn[w] && WAddr[w*AW +: AW] != '0) mreg[WAddr[w*AW +: AW]] = WData[w*DW +: DW];
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        WEn = '0; WAddr = '0; WData = '0; WRetire = '0;
        IssueEn = 1'b0; IssueAddr = '0;
    endtask

    task automatic clk_step();
        @(posedge Clk);
        m_step();
        #1;
    endtask

    task automatic model_check(string tag);
        chk($sformatf("%s rdata0", tag), 64'(RData[0 +: DW]), 64'(m_rdata(0)));
        chk($sformatf("%s rdata1", tag), 64'(RData[DW +: DW]), 64'(m_rdata(1)));
        chk($sformatf("%s rbusy", tag), 64'(RBusy), 64'({m_busy(1), m_busy(0)}));
        chk($sformatf("%s ready", tag), 64'(IssueReady), 64'(m_ready()));
        chk($sformatf("%s err", tag), 64'(ErrUnderflow), 64'(merr));
    endtask

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  wret;
        logic        ien;
        logic [4:0]  ia;
        logic [4:0]  ra0, ra1;
        logic [31:0] rd0, rd1;
        logic [1:0]  busy;
        logic        rdy;
        logic        err;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // wen  wa0  wa1  wd0           wd1    wret ien ia  ra0 ra1 | rd0          rd1           busy rdy err
        tbl[0]  = '{2'b01, 5, 0, 32'hDEADBEEF, 0,     2'b00, 0, 0, 5, 0, 32'hDEADBEEF, 0,            2'b00, 1, 0};
        tbl[1]  = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0};
        tbl[2]  = '{2'b01, 0, 0, 32'h12345678, 0,     2'b01, 0, 0, 0, 5, 0,            32'hDEADBEEF, 2'b00, 1, 0};
        tbl[3]  = '{2'b00, 0, 0, 0,            0,     2'b00, 1, 0, 0, 5, 0,            32'hDEADBEEF, 2'b00, 1, 0};
        tbl[4]  = '{2'b11, 7, 7, 32'h11,       32'h22, 2'b00, 0, 0, 7, 7, 32'h22,      32'h22,       2'b00, 1, 0};
        tbl[5]  = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 0, 7, 5, 32'h22,       32'hDEADBEEF, 2'b00, 1, 0};
        tbl[6]  = '{2'b00, 0, 0, 0,            0,     2'b00, 1, 3, 3, 5, 0,            32'hDEADBEEF, 2'b00, 1, 0};
        tbl[7]  = '{2'b00, 0, 0, 0,            0,     2'b00, 1, 3, 3, 5, 0,            32'hDEADBEEF, 2'b01, 1, 0};
        tbl[8]  = '{2'b00, 0, 0, 0,            0,     2'b00, 1, 3, 3, 5, 0,            32'hDEADBEEF, 2'b01, 1, 0};
        tbl[9]  = '{2'b00, 0, 0, 0,            0,     2'b00, 1, 3, 3, 5, 0,            32'hDEADBEEF, 2'b01, 0, 0};
        tbl[10] = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 3, 3, 5, 0,            32'hDEADBEEF, 2'b01, 0, 0};
        tbl[11] = '{2'b01, 3, 0, 32'hAAAA,     0,     2'b01, 1, 3, 3, 5, 32'hAAAA,     32'hDEADBEEF, 2'b01, 1, 0};
        tbl[12] = '{2'b11, 3, 3, 32'h1,        32'h2, 2'b11, 0, 3, 3, 5, 32'h2,        32'hDEADBEEF, 2'b01, 1, 0};
        tbl[13] = '{2'b01, 3, 0, 32'h3,        0,     2'b01, 0, 3, 3, 5, 32'h3,        32'hDEADBEEF, 2'b00, 1, 0};
        tbl[14] = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 0, 3, 5, 32'h3,        32'hDEADBEEF, 2'b00, 1, 0};
        tbl[15] = '{2'b00, 0, 0, 0,            0,     2'b00, 1, 9, 9, 5, 0,            32'hDEADBEEF, 2'b00, 1, 0};
        tbl[16] = '{2'b01, 9, 0, 32'h99,       0,     2'b01, 1, 9, 9, 5, 32'h99,       32'hDEADBEEF, 2'b01, 1, 0};
        tbl[17] = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 9, 9, 5, 32'h99,       32'hDEADBEEF, 2'b01, 1, 0};
        tbl[18] = '{2'b01, 9, 0, 32'h9A,       0,     2'b01, 0, 0, 9, 5, 32'h9A,       32'hDEADBEEF, 2'b00, 1, 0};
        tbl[19] = '{2'b01, 9, 0, 32'h9B,       0,     2'b01, 0, 0, 9, 5, 32'h9B,       32'hDEADBEEF, 2'b00, 1, 0};
        tbl[20] = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 0, 9, 5, 32'h9B,       32'hDEADBEEF, 2'b00, 1, 1};
        tbl[21] = '{2'b00, 0, 0, 0,            0,     2'b00, 0, 0, 0, 9, 0,            32'h9B,       2'b00, 1, 1};

        Reset = 1'b1;
        RAddr = '0;
        idle();
        clk_step();
        clk_step();
        Reset = 1'b0;

        // Post-reset sweep of every register on both read ports
        for (int r = 0; r < 32; r++) begin
            RAddr     = {AW'(r), AW'(r)};
            IssueAddr = AW'(r);
            @(negedge Clk);
            chk($sformatf("rst r%0d rdata0", r), 64'(RData[0 +: DW]), 64'd0);
            chk($sformatf("rst r%0d rdata1", r), 64'(RData[DW +: DW]), 64'd0);
            chk($sformatf("rst r%0d rbusy", r), 64'(RBusy), 64'd0);
            chk($sformatf("rst r%0d ready", r), 64'(IssueReady), 64'd1);
        end
        chk("rst err", 64'(ErrUnderflow), 64'd0);
        @(posedge Clk);
        m_step();
        #1;

        // Directed vector table
        for (int i = 0; i < 22; i++) begin
            WEn       = tbl[i].wen;
            WAddr     = {tbl[i].wa1, tbl[i].wa0};
            WData     = {tbl[i].wd1, tbl[i].wd0};
            WRetire   = tbl[i].wret;
            IssueEn   = tbl[i].ien;
            IssueAddr = tbl[i].ia;
            RAddr     = {tbl[i].ra1, tbl[i].ra0};
            @(negedge Clk);
            chk($sformatf("vec%0d rdata0", i), 64'(RData[0 +: DW]), 64'(tbl[i].rd0));
            chk($sformatf("vec%0d rdata1", i), 64'(RData[DW +: DW]), 64'(tbl[i].rd1));
            chk($sformatf("vec%0d rbusy", i), 64'(RBusy), 64'(tbl[i].busy));
            chk($sformatf("vec%0d ready", i), 64'(IssueReady), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d err", i), 64'(ErrUnderflow), 64'(tbl[i].err));
            clk_step();
        end

        // Reset wins over simultaneous write, retire and issue
        Reset     = 1'b1;
        WEn       = 2'b11;
        WAddr     = {5'd5, 5'd4};
        WData     = {32'hCAFE0005, 32'hCAFE0004};
        WRetire   = 2'b11;
        IssueEn   = 1'b1;
        IssueAddr = 5'd4;
        clk_step();
        Reset = 1'b0;
        idle();
        IssueAddr = 5'd4;
        RAddr     = {5'd5, 5'd4};
        @(negedge Clk);
        chk("rstwin rdata0", 64'(RData[0 +: DW]), 64'd0);
        chk("rstwin rdata1", 64'(RData[DW +: DW]), 64'd0);
        chk("rstwin rbusy", 64'(RBusy), 64'd0);
        chk("rstwin ready", 64'(IssueReady), 64'd1);
        chk("rstwin err", 64'(ErrUnderflow), 64'd0);
        RAddr = {5'd9, 5'd7};
        @(negedge Clk);
        chk("rstwin r7", 64'(RData[0 +: DW]), 64'd0);
        chk("rstwin r9", 64'(RData[DW +: DW]), 64'd0);
        clk_step();

        // Random traffic on a narrow address window against the model
        for (int c = 0; c < 3000; c++) begin
            Reset     = ($urandom_range(0, 149) == 0);
            WEn       = NW'($urandom_range(0, 3));
            WAddr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            WData     = {$urandom, $urandom};
            WRetire   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            IssueEn   = ($urandom_range(0, 2) != 0);
            IssueAddr = AW'($urandom_range(0, 7));
            RAddr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            @(negedge Clk);
            model_check($sformatf("rnd%0d", c));
            clk_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
